wbdbgbus_wb_arbiter: RTL and testbench

WBDBGBUS_WB_ARBITER -- requirements
Module: wbdbgbus_wb_arbiter

---
 rtl/wbdbgbus_wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wbdbgbus_wb_arbiter.sv | 515 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbdbgbus_wb_arbiter.sv
// Two-master Wishbone pipelined arbiter: m0 is the debug bus, m1 the CPU.
// Tracks outstanding requests and aborts the owner with an err pulse on slave timeout.
module wbdbgbus_wb_arbiter #(
    parameter int unsigned TIMEOUT_CLKS = 1024,
    parameter int unsigned ROUND_ROBIN  = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic        o_m0_stall,
    output logic [31:0] o_m0_data,

    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic        o_m1_stall,
    output logic [31:0] o_m1_data,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMEOUT_RELOAD = TW'(TIMEOUT_CLKS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;          // 1: m1 was granted most recently
    logic [7:0]    outstanding_q, outstanding_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          abort_q, abort_d;

    logic own0, own1;
    logic accept, resp, grant_change;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = (ROUND_ROBIN != 0 && !last_q) ? GNT1 : GNT0;
                end else if (i_m0_cyc) begin
                    state_d = GNT0;
                end else if (i_m1_cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!i_m0_cyc) state_d = i_m1_cyc ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!i_m1_cyc) state_d = i_m0_cyc ? GNT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d == GNT0) begin
            last_d = 1'b0;
        end else if (state_d == GNT1) begin
            last_d = 1'b1;
        end
    end

    // During the abort cycle the owner is cut off from the slave entirely.
    assign own0 = (state_q == GNT0) && !abort_q;
    assign own1 = (state_q == GNT1) && !abort_q;

    assign accept       = o_wb_stb && !i_wb_stall;
    assign resp         = (own0 || own1) && (i_wb_ack || i_wb_err);
    assign grant_change = (state_d != state_q);

    assign abort_d = !grant_change && !abort_q && (outstanding_q != 8'd0) &&
                     (timeout_q == TW'(1));

    always_comb begin
        outstanding_d = outstanding_q;
        if (grant_change || abort_d) begin
            outstanding_d = 8'd0;
        end else if (accept && !resp) begin
            if (outstanding_q != 8'hff) outstanding_d = outstanding_q + 8'd1;
        end else if (resp && !accept) begin
            if (outstanding_q != 8'd0) outstanding_d = outstanding_q - 8'd1;
        end
    end

    always_comb begin
        timeout_d = timeout_q;
        if (grant_change || abort_d || resp || (outstanding_q == 8'd0)) begin
            timeout_d = TIMEOUT_RELOAD;
        end else if (timeout_q != '0) begin
            timeout_d = timeout_q - TW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            outstanding_q <= 8'd0;
            timeout_q     <= TIMEOUT_RELOAD;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            outstanding_q <= outstanding_d;
            timeout_q     <= timeout_d;
            abort_q       <= abort_d;
        end
    end

    always_comb begin
        o_wb_cyc   = 1'b0;
        o_wb_stb   = 1'b0;
        o_wb_we    = 1'b0;
        o_wb_addr  = 32'd0;
        o_wb_data  = 32'd0;
        o_m0_ack   = 1'b0;
        o_m0_err   = 1'b0;
        o_m0_stall = 1'b1;
        o_m0_data  = 32'd0;
        o_m1_ack   = 1'b0;
        o_m1_err   = 1'b0;
        o_m1_stall = 1'b1;
        o_m1_data  = 32'd0;
        if (own0) begin
            o_wb_cyc   = i_m0_cyc;
            o_wb_stb   = i_m0_stb;
            o_wb_we    = i_m0_we;
            o_wb_addr  = i_m0_addr;
            o_wb_data  = i_m0_data;
            o_m0_ack   = i_wb_ack;
            o_m0_err   = i_wb_err;
            o_m0_stall = i_wb_stall;
            o_m0_data  = i_wb_data;
        end else if (own1) begin
            o_wb_cyc   = i_m1_cyc;
            o_wb_stb   = i_m1_stb;
            o_wb_we    = i_m1_we;
            o_wb_addr  = i_m1_addr;
            o_wb_data  = i_m1_data;
            o_m1_ack   = i_wb_ack;
            o_m1_err   = i_wb_err;
            o_m1_stall = i_wb_stall;
            o_m1_data  = i_wb_data;
        end
        if (abort_q && (state_q == GNT0)) o_m0_err = 1'b1;
        if (abort_q && (state_q == GNT1)) o_m1_err = 1'b1;
    end

endmodule

// File: tb/tb_wbdbgbus_wb_arbiter.sv
// Bench for wbdbgbus_wb_arbiter: two instances (fixed priority and round robin) share stimulus,
// directed scenarios plus a randomized run against a behavioural arbitration model.
module tb_wbdbgbus_wb_arbiter;

    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_addr[2];
    logic [31:0] m_data[2];
    logic        wb_ack, wb_err, wb_stall;
    logic [31:0] wb_rdata;

    logic        o_wb_cyc [2];
    logic        o_wb_stb [2];
    logic        o_wb_we  [2];
    logic [31:0] o_wb_addr[2];
    logic [31:0] o_wb_data[2];
    logic        o_ack  [2][2];
    logic        o_err  [2][2];
    logic        o_stall[2][2];
    logic [31:0] o_rdata[2][2];
    logic [136:0] dut_vec[2];

    int checks = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        wbdbgbus_wb_arbiter #(
            .TIMEOUT_CLKS(TO),
            .ROUND_ROBIN (g)
        ) u_dut (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_m0_cyc  (m_cyc[0]),
            .i_m0_stb  (m_stb[0]),
            .i_m0_we   (m_we[0]),
            .i_m0_addr (m_addr[0]),
            .i_m0_data (m_data[0]),
            .o_m0_ack  (o_ack[g][0]),
            .o_m0_err  (o_err[g][0]),
            .o_m0_stall(o_stall[g][0]),
            .o_m0_data (o_rdata[g][0]),
            .i_m1_cyc  (m_cyc[1]),
            .i_m1_stb  (m_stb[1]),
            .i_m1_we   (m_we[1]),
            .i_m1_addr (m_addr[1]),
            .i_m1_data (m_data[1]),
            .o_m1_ack  (o_ack[g][1]),
            .o_m1_err  (o_err[g][1]),
            .o_m1_stall(o_stall[g][1]),
            .o_m1_data (o_rdata[g][1]),
            .o_wb_cyc  (o_wb_cyc[g]),
            .o_wb_stb  (o_wb_stb[g]),
            .o_wb_we   (o_wb_we[g]),
            .o_wb_addr (o_wb_addr[g]),
            .o_wb_data (o_wb_data[g]),
            .i_wb_ack  (wb_ack),
            .i_wb_err  (wb_err),
            .i_wb_stall(wb_stall),
            .i_wb_data (wb_rdata)
        );
        assign dut_vec[g] = {o_wb_cyc[g], o_wb_stb[g], o_wb_we[g], o_wb_addr[g], o_wb_data[g],
                             o_ack[g][0], o_err[g][0], o_stall[g][0], o_rdata[g][0],
                             o_ack[g][1], o_err[g][1], o_stall[g][1], o_rdata[g][1]};
    end

    // Reference model: owner -1 means nobody holds the bus; waited counts idle cycles
    // spent with requests pending and no slave response.
    int own_m  [2] = '{-1, -1};
    int last_m [2] = '{1, 1};
    int pend_m [2] = '{0, 0};
    int wait_m [2] = '{0, 0};
    bit abort_m[2] = '{1'b0, 1'b0};

    bit m_act[2], m_resp[2], m_acc[2];
    int m_nxt[2], m_pend_nx[2];

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            m_act[g]  = (own_m[g] >= 0) && !abort_m[g];
            m_resp[g] = m_act[g] && (wb_ack || wb_err);
            m_acc[g]  = m_act[g] && !wb_stall && ((own_m[g] == 0) ? m_stb[0] : m_stb[1]);
            m_nxt[g]  = own_m[g];
            if (own_m[g] < 0) begin
                if (m_cyc[0] && m_cyc[1]) m_nxt[g] = (g == 1) ? 1 - last_m[g] : 0;
                else if (m_cyc[0])        m_nxt[g] = 0;
                else if (m_cyc[1])        m_nxt[g] = 1;
            end else if (!((own_m[g] == 0) ? m_cyc[0] : m_cyc[1])) begin
                if ((own_m[g] == 0) ? m_cyc[1] : m_cyc[0]) m_nxt[g] = 1 - own_m[g];
                else                                       m_nxt[g] = -1;
            end
            m_pend_nx[g] = pend_m[g] + (m_acc[g] ? 1 : 0) - (m_resp[g] ? 1 : 0);
            if (m_pend_nx[g] > 255) m_pend_nx[g] = 255;
            if (m_pend_nx[g] < 0)   m_pend_nx[g] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                own_m[g]   <= -1;
                last_m[g]  <= 1;
                pend_m[g]  <= 0;
                wait_m[g]  <= 0;
                abort_m[g] <= 1'b0;
            end else begin
                own_m[g] <= m_nxt[g];
                if (m_nxt[g] >= 0) last_m[g] <= m_nxt[g];
                if (m_nxt[g] != own_m[g]) begin
                    pend_m[g]  <= 0;
                    wait_m[g]  <= 0;
                    abort_m[g] <= 1'b0;
                end else if (!abort_m[g] && pend_m[g] > 0 && wait_m[g] == int'(TO) - 1) begin
                    pend_m[g]  <= 0;
                    wait_m[g]  <= 0;
                    abort_m[g] <= 1'b1;
                end else begin
                    abort_m[g] <= 1'b0;
                    pend_m[g]  <= m_pend_nx[g];
                    wait_m[g]  <= (pend_m[g] == 0 || m_resp[g]) ? 0 : wait_m[g] + 1;
                end
            end
        end
    end

    function automatic logic [136:0] exp_vec(int g);
        int          o;
        logic        c, s, w;
        logic [31:0] a, d;
        logic        ak[2], er[2], st[2];
        logic [31:0] rd[2];
        o = (own_m[g] >= 0 && !abort_m[g]) ? own_m[g] : -1;
        c = (o == 0) ? m_cyc[0]  : (o == 1) ? m_cyc[1]  : 1'b0;
        s = (o == 0) ? m_stb[0]  : (o == 1) ? m_stb[1]  : 1'b0;
        w = (o == 0) ? m_we[0]   : (o == 1) ? m_we[1]   : 1'b0;
        a = (o == 0) ? m_addr[0] : (o == 1) ? m_addr[1] : 32'd0;
        d = (o == 0) ? m_data[0] : (o == 1) ? m_data[1] : 32'd0;
        for (int m = 0; m < 2; m++) begin
            ak[m] = (o == m) && wb_ack;
            er[m] = ((o == m) && wb_err) || (abort_m[g] && own_m[g] == m);
            st[m] = (o == m) ? wb_stall : 1'b1;
            rd[m] = (o == m) ? wb_rdata : 32'd0;
        end
        return {c, s, w, a, d, ak[0], er[0], st[0], rd[0], ak[1], er[1], st[1], rd[1]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({o_wb_cyc[g], o_wb_stb[g], o_wb_we[g], o_wb_addr[g], o_wb_data[g]} !== '0) begin
                failures++;
                $display("FAIL reset_wb dut%0d: got %h want 0", g,
                         {o_wb_cyc[g], o_wb_stb[g], o_wb_we[g], o_wb_addr[g], o_wb_data[g]});
            end
            checks++;
            if ({o_stall[g][0], o_stall[g][1]} !== 2'b11) begin
                failures++;
                $display("FAIL reset_stall dut%0d: got %b want 11", g,
                         {o_stall[g][0], o_stall[g][1]});
            end
            checks++;
            if ({o_ack[g][0], o_ack[g][1], o_err[g][0], o_err[g][1],
                 o_rdata[g][0], o_rdata[g][1]} !== '0) begin
                failures++;
                $display("FAIL reset_resp dut%0d: got %h want 0", g,
                         {o_ack[g][0], o_ack[g][1], o_err[g][0], o_err[g][1],
                          o_rdata[g][0], o_rdata[g][1]});
            end
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_wb_cyc[0], o_stall[0][0], o_stall[0][1]} !== 3'b011) begin
            failures++;
            $display("FAIL reset_release: got %b want 011",
                     {o_wb_cyc[0], o_stall[0][0], o_stall[0][1]});
        end
        step();
    endtask

    task automatic test_single_write();
        logic [66:0] want;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
        m_addr[1] = 32'h10; m_data[1] = 32'hA5; wb_stall = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({o_wb_cyc[g], o_stall[g][1]} !== 2'b01) begin
                failures++;
                $display("FAIL sw_latency dut%0d: got cyc/stall %b want 01", g,
                         {o_wb_cyc[g], o_stall[g][1]});
            end
        end
        step();
        @(negedge clk);
        want = {1'b1, 1'b1, 1'b1, 32'h10, 32'hA5};
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({o_wb_cyc[g], o_wb_stb[g], o_wb_we[g], o_wb_addr[g], o_wb_data[g]} !== want) begin
                failures++;
                $display("FAIL sw_slave dut%0d: got %h want %h", g,
                         {o_wb_cyc[g], o_wb_stb[g], o_wb_we[g], o_wb_addr[g], o_wb_data[g]}, want);
            end
        end
        step();
        m_stb[1] = 1'b0; wb_ack = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({o_ack[g][0], o_ack[g][1]} !== 2'b01) begin
                failures++;
                $display("FAIL sw_ack dut%0d: got m0/m1 ack %b want 01", g,
                         {o_ack[g][0], o_ack[g][1]});
            end
        end
        checks++;
        if (gen_dut[0].u_dut.outstanding_q !== 8'd1) begin
            failures++;
            $display("FAIL sw_outstanding: got %0d want 1", gen_dut[0].u_dut.outstanding_q);
        end
        step();
        wb_ack = 1'b0; m_cyc[1] = 1'b0; m_we[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (gen_dut[0].u_dut.outstanding_q !== 8'd0) begin
            failures++;
            $display("FAIL sw_drain: got %0d want 0", gen_dut[0].u_dut.outstanding_q);
        end
        step();
    endtask

    task automatic test_fixed_priority();
        m_addr[0] = 32'h100; m_addr[1] = 32'h200;
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({o_wb_addr[0], o_stall[0][0], o_stall[0][1]} !== {32'h100, 2'b01}) begin
                failures++;
                $display("FAIL fp_hold cycle%0d: got addr %h stall %b want 100 01", i,
                         o_wb_addr[0], {o_stall[0][0], o_stall[0][1]});
            end
            step();
        end
        m_cyc[0] = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({o_wb_cyc[0], o_wb_addr[0], o_stall[0][1]} !== {1'b1, 32'h200, 1'b0}) begin
            failures++;
            $display("FAIL fp_handover: got cyc %b addr %h m1 stall %b want 1 200 0",
                     o_wb_cyc[0], o_wb_addr[0], o_stall[0][1]);
        end
        step();
        m_cyc[1] = 1'b0;
        step();
        step();
    endtask

    task automatic test_round_robin();
        int e;
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            e = k % 2;
            m_cyc[1-e] = 1'b1;
            m_stb[e] = 1'b1;
            wb_stall = 1'b0;
            @(negedge clk);
            checks++;
            if ({o_wb_cyc[1], o_wb_addr[1]} !== {1'b1, m_addr[e]}) begin
                failures++;
                $display("FAIL rr_grant%0d: got cyc %b addr %h want 1 %h", k,
                         o_wb_cyc[1], o_wb_addr[1], m_addr[e]);
            end
            step();
            m_stb[e] = 1'b0; wb_ack = 1'b1;
            @(negedge clk);
            checks++;
            if (o_ack[1][e] !== 1'b1 || o_ack[1][1-e] !== 1'b0) begin
                failures++;
                $display("FAIL rr_ack%0d: got owner ack %b other ack %b want 1 0", k,
                         o_ack[1][e], o_ack[1][1-e]);
            end
            step();
            wb_ack = 1'b0; m_cyc[e] = 1'b0;
            step();
        end
        m_cyc[0] = 1'b0;
        step();
        m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({o_wb_addr[0], o_wb_addr[1]} !== {32'h100, 32'h200}) begin
            failures++;
            $display("FAIL rr_idle_contention: got fixed %h rr %h want 100 200",
                     o_wb_addr[0], o_wb_addr[1]);
        end
        step();
        m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        int found;
        m_addr[0] = 32'h40; m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        wb_stall = 1'b0;
        step();
        step();
        m_stb[0] = 1'b0;
        found = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            wb_ack = (c == 8);
            @(negedge clk);
            if (o_err[0][0] === 1'b1) begin
                found = c;
                break;
            end
        end
        checks++;
        if (found != 8) begin
            failures++;
            $display("FAIL to_when: err seen at cycle %0d want 8 (0 = never)", found);
        end
        checks++;
        if ({o_wb_cyc[0], o_wb_stb[0], o_stall[0][0], o_ack[0][0]} !== 4'b0010) begin
            failures++;
            $display("FAIL to_abort_outputs: got cyc/stb/stall/ack %b want 0010",
                     {o_wb_cyc[0], o_wb_stb[0], o_stall[0][0], o_ack[0][0]});
        end
        checks++;
        if (gen_dut[0].u_dut.outstanding_q !== 8'd0) begin
            failures++;
            $display("FAIL to_outstanding: got %0d want 0", gen_dut[0].u_dut.outstanding_q);
        end
        checks++;
        if ({o_err[1][0], o_err[1][1]} !== 2'b10) begin
            failures++;
            $display("FAIL to_rr_dut: got m0/m1 err %b want 10", {o_err[1][0], o_err[1][1]});
        end
        step();
        wb_ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_err[0][0], o_wb_cyc[0]} !== 2'b01) begin
            failures++;
            $display("FAIL to_after: got err/cyc %b want 01", {o_err[0][0], o_wb_cyc[0]});
        end
        m_cyc[0] = 1'b0;
        step();
        step();
    endtask

    task automatic test_pipeline();
        logic [31:0] rd;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 32'h1000;
        wb_stall = 1'b0;
        step();
        step();
        m_addr[0] = 32'h1004; wb_stall = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_stall[0][0], o_wb_addr[0]} !== {1'b1, 32'h1004}) begin
            failures++;
            $display("FAIL pl_stall: got stall %b addr %h want 1 1004", o_stall[0][0],
                     o_wb_addr[0]);
        end
        checks++;
        if (gen_dut[0].u_dut.outstanding_q !== 8'd1) begin
            failures++;
            $display("FAIL pl_first: got %0d want 1", gen_dut[0].u_dut.outstanding_q);
        end
        step();
        wb_stall = 1'b0;
        step();
        m_addr[0] = 32'h1008;
        step();
        m_stb[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd = 32'hD000_0000 + 32'(i);
            wb_ack = 1'b1; wb_rdata = rd;
            @(negedge clk);
            checks++;
            if ({o_ack[0][0], o_rdata[0][0], o_rdata[0][1]} !== {1'b1, rd, 32'd0}) begin
                failures++;
                $display("FAIL pl_ack%0d: got ack %b data %h other %h want 1 %h 0", i,
                         o_ack[0][0], o_rdata[0][0], o_rdata[0][1], rd);
            end
            checks++;
            if (gen_dut[0].u_dut.outstanding_q !== 8'(3 - i)) begin
                failures++;
                $display("FAIL pl_count%0d: got %0d want %0d", i,
                         gen_dut[0].u_dut.outstanding_q, 3 - i);
            end
            step();
        end
        wb_ack = 1'b0; wb_rdata = 32'd0;
        @(negedge clk);
        checks++;
        if (gen_dut[0].u_dut.outstanding_q !== 8'd0 || o_err[0][0] !== 1'b0) begin
            failures++;
            $display("FAIL pl_drain: got outstanding %0d err %b want 0 0",
                     gen_dut[0].u_dut.outstanding_q, o_err[0][0]);
        end
        m_cyc[0] = 1'b0;
        step();
        step();
    endtask

    task automatic test_async_reset();
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h20;
        wb_stall = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (o_wb_cyc[0] !== 1'b1) begin
            failures++;
            $display("FAIL ar_pre: got cyc %b want 1", o_wb_cyc[0]);
        end
        #1 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({o_wb_cyc[g], o_wb_stb[g], o_stall[g][1]} !== 3'b001) begin
                failures++;
                $display("FAIL ar_drop dut%0d: got cyc/stb/stall %b want 001", g,
                         {o_wb_cyc[g], o_wb_stb[g], o_stall[g][1]});
            end
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0; wb_stall = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_random();
        int div;
        for (int c = 0; c < 600; c++) begin
            div = (c < 200) ? 2 : (c < 400) ? 6 : 14;
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 7) == 0) m_cyc[m] = ~m_cyc[m];
                m_stb[m]  = m_cyc[m] & 1'($urandom_range(0, 1));
                m_we[m]   = 1'($urandom_range(0, 1));
                m_addr[m] = $urandom;
                m_data[m] = $urandom;
            end
            wb_ack   = ($urandom_range(0, div) == 0);
            wb_err   = ($urandom_range(0, 15) == 0);
            wb_stall = ($urandom_range(0, 3) == 0);
            wb_rdata = $urandom;
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                checks++;
                if (dut_vec[g] !== exp_vec(g)) begin
                    failures++;
                    $display("FAIL rand dut%0d cycle%0d: got %h want %h", g, c, dut_vec[g],
                             exp_vec(g));
                end
            end
            step();
        end
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0;
            m_stb[m] = 1'b0;
        end
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_cyc[m]  = 1'b0;
            m_stb[m]  = 1'b0;
            m_we[m]   = 1'b0;
            m_addr[m] = 32'd0;
            m_data[m] = 32'd0;
        end
        wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_rdata = 32'd0;
        test_reset();
        test_single_write();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_pipeline();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
